// File: rtl/vend_credit_reg.sv
// Customer credit balance register for the vending machine: load, coin add,
// purchase deduct with saturation/insufficient-funds flags, and refund payout.
module vend_credit_reg #(
    parameter int WIDTH       = 8,
    parameter int MAX_CREDIT  = 200,
    parameter int CHANGE_UNIT = 5
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             add_en,
    input  logic [WIDTH-1:0] add_val,
    input  logic             sub_en,
    input  logic [WIDTH-1:0] sub_val,
    input  logic             refund_req,
    input  logic             change_ack,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             change_valid,
    output logic [WIDTH-1:0] change_amt,
    output logic             sat,
    output logic             err,
    output logic             done
);

    typedef enum logic {
        IDLE,
        DISPENSE
    } state_t;

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_CREDIT);
    localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_CREDIT);
    localparam logic [WIDTH-1:0] UNIT_Q = WIDTH'(CHANGE_UNIT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic             short_funds;
    logic             last_beat;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            q_q    <= '0;
            sat_q  <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sat_q  <= sat_d;
            err_q  <= err_d;
            done_q <= done_d;
        end
    end

    // One extra bit so coin + balance can never wrap before the clamp.
    always_comb begin
        sum_w       = {1'b0, q_q} + (add_en ? {1'b0, add_val} : '0);
        short_funds = sub_en && ({1'b0, sub_val} > sum_w);
        diff_w      = sum_w - (sub_en ? {1'b0, sub_val} : '0);
        last_beat   = change_ack && (q_q <= UNIT_Q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!load && refund_req && (q_q != '0)) state_d = DISPENSE;
            DISPENSE: if (last_beat) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == DISPENSE);
        change_valid = (state_q == DISPENSE);
        change_amt   = '0;
        if (state_q == DISPENSE) begin
            change_amt = (q_q < UNIT_Q) ? q_q : UNIT_Q;
        end
    end

    always_comb begin
        q_d    = q_q;
        sat_d  = 1'b0;
        err_d  = 1'b0;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    q_d   = (d > MAX_Q) ? MAX_Q : d;
                    sat_d = (d > MAX_Q);
                end else if (refund_req) begin
                    err_d = (q_q == '0);
                end else if (short_funds) begin
                    // Purchase rejected but the coin is still credited.
                    err_d = 1'b1;
                    q_d   = (sum_w > MAX_W) ? MAX_Q : sum_w[WIDTH-1:0];
                    sat_d = (sum_w > MAX_W);
                end else begin
                    q_d   = (diff_w > MAX_W) ? MAX_Q : diff_w[WIDTH-1:0];
                    sat_d = (diff_w > MAX_W);
                end
            end
            DISPENSE: begin
                err_d = load || add_en || sub_en || refund_req;
                if (change_ack) begin
                    q_d    = q_q - change_amt;
                    done_d = last_beat;
                end
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    assign q    = q_q;
    assign sat  = sat_q;
    assign err  = err_q;
    assign done = done_q;

endmodule

// File: tb/tb_vend_credit_reg.sv
// Directed self-checking bench for vend_credit_reg with hand-computed expectations.
module tb_vend_credit_reg;

    logic       clk;
    logic       clear_n;
    logic       load;
    logic [7:0] d;
    logic       add_en;
    logic [7:0] add_val;
    logic       sub_en;
    logic [7:0] sub_val;
    logic       refund_req;
    logic       change_ack;
    logic [7:0] q;
    logic       busy;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       sat;
    logic       err;
    logic       done;

    int total;
    int bad;

    vend_credit_reg #(
        .WIDTH(8),
        .MAX_CREDIT(200),
        .CHANGE_UNIT(5)
    ) dut (
        .clk(clk),
        .clear_n(clear_n),
        .load(load),
        .d(d),
        .add_en(add_en),
        .add_val(add_val),
        .sub_en(sub_en),
        .sub_val(sub_val),
        .refund_req(refund_req),
        .change_ack(change_ack),
        .q(q),
        .busy(busy),
        .change_valid(change_valid),
        .change_amt(change_amt),
        .sat(sat),
        .err(err),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        clear_n    = 1'b0;
        load       = 1'b1;
        d          = 8'd10;
        add_en     = 1'b0;
        add_val    = 8'd0;
        sub_en     = 1'b0;
        sub_val    = 8'd0;
        refund_req = 1'b0;
        change_ack = 1'b0;

        // Reset dominates a simultaneous load.
        applyStimulus();
        applyStimulus();
        checkOutput("rst_q", 32'(q), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(change_valid), 32'd0);
        checkOutput("rst_amt", 32'(change_amt), 32'd0);
        checkOutput("rst_sat", 32'(sat), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);

        clear_n = 1'b1;
        applyStimulus();
        checkOutput("load10_q", 32'(q), 32'd10);
        checkOutput("load10_sat", 32'(sat), 32'd0);

        // Saturation on add and on load.
        d = 8'd150;
        applyStimulus();
        checkOutput("load150_q", 32'(q), 32'd150);
        load    = 1'b0;
        add_en  = 1'b1;
        add_val = 8'd60;
        applyStimulus();
        checkOutput("addsat_q", 32'(q), 32'd200);
        checkOutput("addsat_sat", 32'(sat), 32'd1);
        add_en = 1'b0;
        applyStimulus();
        checkOutput("addsat_pulse_q", 32'(q), 32'd200);
        checkOutput("addsat_pulse_sat", 32'(sat), 32'd0);
        load = 1'b1;
        d    = 8'd255;
        applyStimulus();
        checkOutput("load255_q", 32'(q), 32'd200);
        checkOutput("load255_sat", 32'(sat), 32'd1);
        load = 1'b0;
        applyStimulus();
        checkOutput("load255_pulse_sat", 32'(sat), 32'd0);

        // Insufficient funds, then exact-price purchase with a coin.
        load = 1'b1;
        d    = 8'd20;
        applyStimulus();
        load    = 1'b0;
        sub_en  = 1'b1;
        sub_val = 8'd30;
        applyStimulus();
        checkOutput("short_q", 32'(q), 32'd20);
        checkOutput("short_err", 32'(err), 32'd1);
        add_en  = 1'b1;
        add_val = 8'd10;
        applyStimulus();
        checkOutput("exact_q", 32'(q), 32'd0);
        checkOutput("exact_err", 32'(err), 32'd0);
        add_val = 8'd4;
        sub_val = 8'd9;
        applyStimulus();
        checkOutput("coinkept_q", 32'(q), 32'd4);
        checkOutput("coinkept_err", 32'(err), 32'd1);
        add_en = 1'b0;
        sub_en = 1'b0;

        // Refund with continuous ack: beats 5, 5, 2.
        load = 1'b1;
        d    = 8'd12;
        applyStimulus();
        load       = 1'b0;
        change_ack = 1'b1;
        refund_req = 1'b1;
        applyStimulus();
        refund_req = 1'b0;
        checkOutput("rf_b1_busy", 32'(busy), 32'd1);
        checkOutput("rf_b1_valid", 32'(change_valid), 32'd1);
        checkOutput("rf_b1_amt", 32'(change_amt), 32'd5);
        checkOutput("rf_b1_q", 32'(q), 32'd12);
        applyStimulus();
        checkOutput("rf_b2_q", 32'(q), 32'd7);
        checkOutput("rf_b2_amt", 32'(change_amt), 32'd5);
        checkOutput("rf_b2_busy", 32'(busy), 32'd1);
        applyStimulus();
        checkOutput("rf_b3_q", 32'(q), 32'd2);
        checkOutput("rf_b3_amt", 32'(change_amt), 32'd2);
        checkOutput("rf_b3_busy", 32'(busy), 32'd1);
        checkOutput("rf_b3_done", 32'(done), 32'd0);
        applyStimulus();
        checkOutput("rf_end_q", 32'(q), 32'd0);
        checkOutput("rf_end_busy", 32'(busy), 32'd0);
        checkOutput("rf_end_valid", 32'(change_valid), 32'd0);
        checkOutput("rf_end_amt", 32'(change_amt), 32'd0);
        checkOutput("rf_end_done", 32'(done), 32'd1);
        applyStimulus();
        checkOutput("rf_done_pulse", 32'(done), 32'd0);

        // Refund stalled by the dispenser; a coin during refund is flagged.
        change_ack = 1'b0;
        load       = 1'b1;
        d          = 8'd12;
        applyStimulus();
        load       = 1'b0;
        refund_req = 1'b1;
        applyStimulus();
        refund_req = 1'b0;
        checkOutput("stall_accept_err", 32'(err), 32'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("stall_q", 32'(q), 32'd12);
        checkOutput("stall_amt", 32'(change_amt), 32'd5);
        checkOutput("stall_valid", 32'(change_valid), 32'd1);
        add_en  = 1'b1;
        add_val = 8'd5;
        applyStimulus();
        add_en = 1'b0;
        checkOutput("coin_in_refund_err", 32'(err), 32'd1);
        checkOutput("coin_in_refund_q", 32'(q), 32'd12);
        applyStimulus();
        checkOutput("coin_in_refund_pulse", 32'(err), 32'd0);
        checkOutput("stall_amt2", 32'(change_amt), 32'd5);
        change_ack = 1'b1;
        applyStimulus();
        change_ack = 1'b0;
        checkOutput("mid_q", 32'(q), 32'd7);

        // Reset mid-refund abandons the payout without done.
        clear_n = 1'b0;
        applyStimulus();
        clear_n = 1'b1;
        checkOutput("midrst_q", 32'(q), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_valid", 32'(change_valid), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        applyStimulus();
        checkOutput("midrst_done2", 32'(done), 32'd0);
        refund_req = 1'b1;
        applyStimulus();
        refund_req = 1'b0;
        checkOutput("empty_refund_err", 32'(err), 32'd1);
        checkOutput("empty_refund_busy", 32'(busy), 32'd0);
        applyStimulus();
        checkOutput("empty_refund_pulse", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_credit_reg.md
Name: vend_credit_reg

Overview:
Parametrised successor to the vending machine's fixed-width load/clear register. Holds the customer credit balance and adds coin accumulation, purchase deduction and saturation/insufficient-funds detection. It also contains a refund state machine that pays the balance out in CHANGE_UNIT beats over a valid/ack handshake to the change dispenser. It sits between the coin acceptor/product selector logic and the change dispenser.

Parameters:
WIDTH, 8, bit width of the credit balance and all value ports
MAX_CREDIT, 200, saturation ceiling for the balance; must be at most 2^WIDTH-1
CHANGE_UNIT, 5, maximum value paid out per refund beat; must be at least 1 and at most MAX_CREDIT

Ports:
clk  input  1  system clock; all state changes on the rising edge
clear_n  input  1  synchronous active-low reset; sampled on rising clk
load  input  1  overwrite balance with d
d  input  WIDTH  load value; if above MAX_CREDIT it is clamped to MAX_CREDIT
add_en  input  1  add add_val (coin inserted)
add_val  input  WIDTH  coin value
sub_en  input  1  deduct sub_val (purchase)
sub_val  input  WIDTH  price
refund_req  input  1  start refund of the whole balance
change_ack  input  1  dispenser accepts the current change beat
q  output  WIDTH  current balance
busy  output  1  high while in DISPENSE
change_valid  output  1  a change beat is presented
change_amt  output  WIDTH  value of the presented beat
sat  output  1  one-cycle pulse: a result was clamped to MAX_CREDIT
err  output  1  one-cycle pulse: a request was rejected
done  output  1  one-cycle pulse: refund completed

Behaviour:
- Reset (clear_n=0 at edge): q=0, state=IDLE, busy=0, change_valid=0, change_amt=0, sat=0, err=0, done=0. Reset overrides everything, including mid-refund: pending change is abandoned and no done pulse is issued.
- States: IDLE, DISPENSE.
- IDLE, priority per edge: load > refund_req > add/sub.
- load: q <= min(d, MAX_CREDIT). sat pulses if clamped. Same-cycle add, sub and refund_req are ignored with no err.
- refund_req (no load):
  - if q>0, go to DISPENSE; add/sub that cycle are ignored, with no err.
  - if q=0, err pulses and the block stays in IDLE.
- add/sub arithmetic uses WIDTH+1 bits, with t = q + (add_en ? add_val : 0).
  - sub_en and sub_val > t: err pulses; q <= min(t, MAX_CREDIT), so the coin is kept and the purchase is rejected.
  - otherwise q <= min(t - (sub_en ? sub_val : 0), MAX_CREDIT); sat pulses if clamped.
  - sub_val = t is legal and results in q=0.
- DISPENSE:
  - change_valid=1 and change_amt = min(q, CHANGE_UNIT), combinational from q.
  - On an edge with change_ack=1: q <= q - change_amt. If the new q is 0, go to IDLE and pulse done in the following cycle (registered).
  - change_ack=0: hold q and change_amt stable; change_valid stays high.
  - load, add_en, sub_en or refund_req asserted in DISPENSE: ignored and err pulses; this is how a coin inserted during refund is flagged.
- busy = (state==DISPENSE). change_valid=0 in IDLE.
- The first beat is presented the cycle after refund_req is accepted. One beat per acked cycle gives a maximum throughput of 1 beat/cycle.
- sat, err and done are registered single-cycle pulses; they are never held.
- q never exceeds MAX_CREDIT and never wraps.

Test Plan:
1. clear_n=0 for 2 cycles with load=1, d=10 -> q=0, busy=0, all pulses 0. Release, then load=1, d=10 -> q=10 after 1 edge.
2. q=150, add_en, add_val=60 -> q=200, sat pulse for 1 cycle. Then load d=255 -> q=200, sat pulse.
3. q=20, sub_en, sub_val=30 -> q=20, err pulse. Same cycle add_val=10, sub_val=30 -> q=0, no err.
4. q=12, refund_req, change_ack always 1 -> change_amt beats 5, 5, 2 on consecutive cycles; q goes 7, 2, 0; done pulses once; busy high for 3 cycles.
5. q=12 in refund with change_ack low for 3 cycles -> change_amt held at 5, q held at 12. An add_en pulse during this time -> err pulse, q unchanged.
6. Mid-refund (q=7) drive clear_n=0 -> next edge q=0, IDLE, change_valid=0, no done. refund_req with q=0 -> err pulse, busy stays 0.
